// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the single RegFile write port.
// Port 0 has default priority; port 1 is guaranteed service by a starvation counter.

module regfile_wb_pend_bit #(
  parameter int AW  = 5,
  parameter int IDX = 0
) (
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic          p1_wait_i,
  input  logic [AW-1:0] p1_addr_i,
  output logic          pend_o
);
  // r0 is hardwired, so a write to it can never be a hazard
  if (IDX == 0) begin : g_r0
    assign pend_o = 1'b0;
  end else begin : g_rn
    assign pend_o = (we_i && (wa_i == AW'(IDX))) || (p1_wait_i && (p1_addr_i == AW'(IDX)));
  end
endmodule

module regfile_wb_arbiter #(
  parameter int DW           = 32,
  parameter int AW           = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 p0_valid_i,
  output logic                 p0_ready_o,
  input  logic [AW-1:0]        p0_addr_i,
  input  logic [DW-1:0]        p0_data_i,
  input  logic                 p1_valid_i,
  output logic                 p1_ready_o,
  input  logic [AW-1:0]        p1_addr_i,
  input  logic [DW-1:0]        p1_data_i,
  output logic                 rf_we_o,
  output logic [AW-1:0]        rf_wa_o,
  output logic [DW-1:0]        rf_wd_o,
  output logic [(1<<AW)-1:0]   pending_mask_o
);
  localparam int NREG = 1 << AW;
  localparam int CW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

  localparam logic [0:0] PRIO0 = 1'b0;
  localparam logic [0:0] PRIO1 = 1'b1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  wr_req_t       wr_q, wr_d;
  wr_req_t       p0_req, p1_req;
  logic          p0_xfer, p1_xfer;

  assign p0_req = '{addr: p0_addr_i, data: p0_data_i};
  assign p1_req = '{addr: p1_addr_i, data: p1_data_i};

  // Ready is gated by reset so nothing handshakes while the block is held
  always_comb begin
    p0_ready_o = 1'b0;
    p1_ready_o = 1'b0;
    if (rst_n_i) begin
      if (state_q == PRIO0) begin
        p0_ready_o = 1'b1;
        p1_ready_o = ~p0_valid_i;
      end else begin
        p1_ready_o = 1'b1;
        p0_ready_o = ~p1_valid_i;
      end
    end
  end

  assign p0_xfer = p0_valid_i & p0_ready_o;
  assign p1_xfer = p1_valid_i & p1_ready_o;

  always_comb begin
    cnt_d = '0;
    if (p1_valid_i && !p1_xfer)
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PRIO0:   if (cnt_d == CNT_MAX)          state_d = PRIO1;
      PRIO1:   if (p1_xfer || !p1_valid_i)    state_d = PRIO0;
      default:                                state_d = PRIO0;
    endcase
  end

  // Address/data follow every transfer; enable is suppressed for r0
  always_comb begin
    wr_d = wr_q;
    we_d = 1'b0;
    if (p1_xfer) begin
      wr_d = p1_req;
      we_d = (p1_req.addr != '0);
    end else if (p0_xfer) begin
      wr_d = p0_req;
      we_d = (p0_req.addr != '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= PRIO0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wr_q    <= wr_d;
    end
  end

  assign rf_we_o = we_q;
  assign rf_wa_o = wr_q.addr;
  assign rf_wd_o = wr_q.data;

  for (genvar r = 0; r < NREG; r++) begin : g_pend
    regfile_wb_pend_bit #(.AW(AW), .IDX(r)) u_pend (
      .we_i      (we_q),
      .wa_i      (wr_q.addr),
      .p1_wait_i (p1_valid_i & ~p1_ready_o),
      .p1_addr_i (p1_addr_i),
      .pend_o    (pending_mask_o[r])
    );
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a write scoreboard and a RegFile model.

module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SL = 4;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  logic p0_valid, p0_ready, p1_valid, p1_ready;
  logic [AW-1:0] p0_addr, p1_addr, rf_wa;
  logic [DW-1:0] p0_data, p1_data, rf_wd;
  logic rf_we;
  logic [(1<<AW)-1:0] pending_mask;

  int errs = 0;
  int checks = 0;
  wr_t sb[$];
  logic [DW-1:0] rf_model [0:(1<<AW)-1];

  regfile_wb_arbiter #(.DW(DW), .AW(AW), .STARVE_LIMIT(SL)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .p0_valid_i(p0_valid), .p0_ready_o(p0_ready), .p0_addr_i(p0_addr), .p0_data_i(p0_data),
    .p1_valid_i(p1_valid), .p1_ready_o(p1_ready), .p1_addr_i(p1_addr), .p1_data_i(p1_data),
    .rf_we_o(rf_we), .rf_wa_o(rf_wa), .rf_wd_o(rf_wd), .pending_mask_o(pending_mask)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rf_we) rf_model[rf_wa] <= rf_wd;

  // Every RegFile write must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      checks++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL sb_unexpected: got wa=%0d wd=%h, expected no write", rf_wa, rf_wd);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (rf_wa !== e.a || rf_wd !== e.d) begin
          errs++;
          $display("FAIL sb_write: got wa=%0d wd=%h, expected wa=%0d wd=%h", rf_wa, rf_wd, e.a, e.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.a = a; w.d = d;
    if (a != '0) sb.push_back(w);
  endtask

  task automatic idle();
    p0_valid = 0; p1_valid = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; p0_valid = 1; p1_valid = 1;
    p0_addr = 2; p0_data = 32'h1; p1_addr = 7; p1_data = 32'h2;
    #12;
    chk("reset_p0_ready", p0_ready, 0);
    chk("reset_p1_ready", p1_ready, 0);
    chk("reset_we", rf_we, 0);
    chk("reset_wa", rf_wa, 0);
    chk("reset_wd", rf_wd, 0);
    @(negedge clk); rst_n = 1; #1;
    chk("rel_p0_ready", p0_ready, 1);
    chk("rel_p1_ready", p1_ready, 0);
    idle();
    tick();
  endtask

  task automatic test_single();
    p0_valid = 1; p0_addr = 5; p0_data = 32'hDEADBEEF; #1;
    chk("single_p0_ready", p0_ready, 1);
    push(5, 32'hDEADBEEF);
    tick(); idle(); #1;
    chk("single_we", rf_we, 1);
    chk("single_wa", rf_wa, 5);
    chk("single_wd", rf_wd, 32'hDEADBEEF);
    chk("single_mask", pending_mask, 64'(32'h1 << 5));
    tick();
    chk("single_we_off", rf_we, 0);
    chk("single_mask_off", pending_mask, 0);
  endtask

  task automatic test_zero();
    p1_valid = 1; p1_addr = 0; p1_data = 32'hFFFFFFFF; #1;
    chk("zero_p1_ready", p1_ready, 1);
    chk("zero_mask_req", pending_mask, 0);
    tick(); idle(); #1;
    chk("zero_we", rf_we, 0);
    chk("zero_mask", pending_mask, 0);
    tick();
  endtask

  // p1 starved by continuous p0 traffic: waits SL cycles, then gets a forced grant
  task automatic starve_run(input string tag, input logic [AW-1:0] p1a, input logic [DW-1:0] p1d);
    p1_valid = 1; p1_addr = p1a; p1_data = p1d;
    for (int i = 0; i < SL; i++) begin
      p0_valid = 1; p0_addr = AW'(i + 1); p0_data = 32'h100 + i; #1;
      chk({tag, "_wait_p0_ready"}, p0_ready, 1);
      chk({tag, "_wait_p1_ready"}, p1_ready, 0);
      chk({tag, "_wait_mask"}, pending_mask[p1a], 1);
      push(AW'(i + 1), 32'h100 + i);
      tick();
    end
  endtask

  task automatic test_starvation();
    starve_run("starve", 7, 32'hA5A50007);
    p0_addr = 5; p0_data = 32'h104; #1;
    chk("starve_grant_p1", p1_ready, 1);
    chk("starve_grant_p0", p0_ready, 0);
    push(7, 32'hA5A50007);
    tick(); p1_valid = 0; #1;
    chk("starve_wa", rf_wa, 7);
    chk("starve_resume_p0", p0_ready, 1);
    push(5, 32'h104);
    tick(); idle();
    chk("starve_resume_wa", rf_wa, 5);
    tick();
  endtask

  task automatic test_same_addr();
    p0_valid = 1; p0_addr = 3; p0_data = 32'h11;
    p1_valid = 1; p1_addr = 3; p1_data = 32'h22; #1;
    chk("same_p0_first", p0_ready, 1);
    chk("same_p1_wait", p1_ready, 0);
    push(3, 32'h11);
    tick(); p0_valid = 0; #1;
    chk("same_p1_second", p1_ready, 1);
    chk("same_mask3", pending_mask[3], 1);
    push(3, 32'h22);
    tick(); idle();
    tick(); tick();
    chk("same_readback", rf_model[3], 32'h22);
  endtask

  task automatic test_async_reset();
    starve_run("ar", 9, 32'h9999);
    p0_addr = 6; p0_data = 32'h600; #1;
    chk("ar_forced_grant", p1_ready, 1);
    #2 rst_n = 0; #1;
    chk("ar_we_drop", rf_we, 0);
    chk("ar_ready_drop", p1_ready, 0);
    sb.delete();
    tick();
    @(negedge clk); rst_n = 1; #1;
    chk("ar_rel_p1", p1_ready, 0);
    starve_run("ar2", 9, 32'h9999);
    p0_addr = 6; p0_data = 32'h600; #1;
    chk("ar2_grant_p1", p1_ready, 1);
    push(9, 32'h9999);
    tick(); p1_valid = 0; #1;
    push(6, 32'h600);
    tick(); idle();
    tick(); tick();
  endtask

  initial begin
    idle(); p0_addr = 0; p1_addr = 0; p0_data = 0; p1_data = 0;
    test_reset();
    test_single();
    test_zero();
    test_starvation();
    test_same_addr();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL sb_drain: got %0d writes outstanding, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
